// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp, msip, and registered MTIP/MSIP outputs.
// Optional mtime prescaler is compiled in with `define CLINT_PRESCALE_EN.
module clint_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int unsigned PRESCALE_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  localparam logic [2:0] OFF_MSIP        = 3'd0;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_MTIME_LO    = 3'd4;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd5;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        sel;
  logic        wr;
  logic        rd;
  logic [2:0]  off;
  logic        mtime_wr;
  logic        tick;
  logic [31:0] rd_mux;
  logic        unused_addr_lsb;

  // Handshake: a selected request (bus_valid in window) is always accepted and
  // answered exactly one cycle later with bus_rvalid; there is no back-pressure.
  assign sel      = bus_valid && (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign wr       = sel && bus_we;
  assign rd       = sel && !bus_we;
  assign off      = bus_addr[4:2];
  assign mtime_wr = wr && ((off == OFF_MTIME_LO) || (off == OFF_MTIME_HI));
  assign unused_addr_lsb = ^bus_addr[1:0];

`ifdef CLINT_PRESCALE_EN
  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE_DIV - 1);
  logic [15:0] prescale;

  assign tick = (prescale == PRESCALE_LAST);

  // A write to either mtime half restarts the tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= 16'd0;
    end else if (mtime_wr || tick) begin
      prescale <= 16'd0;
    end else begin
      prescale <= prescale + 16'd1;
    end
  end
`else
  localparam int unsigned unused_prescale_div = PRESCALE_DIV;
  assign tick = 1'b1;
`endif

  always_comb begin
    rd_mux = 32'd0;
    case (off)
      OFF_MSIP:        rd_mux = {31'd0, msip};
      OFF_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      OFF_MTIME_LO:    rd_mux = mtime[31:0];
      OFF_MTIME_HI:    rd_mux = mtime[63:32];
      default:         rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime              <= 64'd0;
      mtimecmp           <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip               <= 1'b0;
      bus_rvalid         <= 1'b0;
      bus_rdata          <= 32'd0;
      timer_interrupt    <= 1'b0;
      software_interrupt <= 1'b0;
    end else begin
      bus_rvalid         <= sel;
      bus_rdata          <= rd ? rd_mux : 32'd0;
      timer_interrupt    <= (mtime >= mtimecmp);
      software_interrupt <= msip;
      if (wr) begin
        case (off)
          OFF_MSIP:        msip            <= bus_wdata[0];
          OFF_MTIMECMP_LO: mtimecmp[31:0]  <= bus_wdata;
          OFF_MTIMECMP_HI: mtimecmp[63:32] <= bus_wdata;
          OFF_MTIME_LO:    mtime[31:0]     <= bus_wdata;
          OFF_MTIME_HI:    mtime[63:32]    <= bus_wdata;
          default: ;
        endcase
      end
      // A software write to mtime wins over the tick so no carry leaks into the written half.
      if (!mtime_wr && tick) begin
        mtime <= mtime + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Randomized bench for clint_timer: a cycle model of the register map checks every output
// each cycle, plus literal checks of reset values, carry, timer/software interrupts and reset.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef CLINT_PRESCALE_EN
  localparam int TB_DIV = 4;
`else
  localparam int TB_DIV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = 32'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        timer_interrupt;
  logic        software_interrupt;

  int checks = 0;
  int errors = 0;

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE_DIV(TB_DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_valid(bus_valid),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid),
    .timer_interrupt(timer_interrupt),
    .software_interrupt(software_interrupt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] m_mtime = 64'd0;
  logic [63:0] m_cmp = '1;
  logic        m_msip = 1'b0;
  int          m_pcnt = 0;
  logic        exp_rvalid = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_ti = 1'b0;
  logic        exp_si = 1'b0;

  function automatic logic [31:0] model_read(int word);
    case (word)
      0: return {31'd0, m_msip};
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return m_mtime[31:0];
      5: return m_mtime[63:32];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_pcnt = 0;
      exp_rvalid = 1'b0; exp_rdata = 32'd0; exp_ti = 1'b0; exp_si = 1'b0;
    end else begin
      logic in_win;
      logic time_written;
      int   word;
      in_win = bus_valid && (bus_addr >= BASE) && (bus_addr <= BASE + 32'd31);
      word = int'((bus_addr - BASE) >> 2);
      exp_ti = (m_mtime >= m_cmp);
      exp_si = m_msip;
      exp_rvalid = in_win;
      exp_rdata = (in_win && !bus_we) ? model_read(word) : 32'd0;
      time_written = 1'b0;
      if (in_win && bus_we) begin
        case (word)
          0: m_msip = bus_wdata[0];
          2: m_cmp = {m_cmp[63:32], bus_wdata};
          3: m_cmp = {bus_wdata, m_cmp[31:0]};
          4: begin m_mtime = {m_mtime[63:32], bus_wdata}; time_written = 1'b1; end
          5: begin m_mtime = {bus_wdata, m_mtime[31:0]}; time_written = 1'b1; end
          default: ;
        endcase
      end
      if (time_written) begin
        m_pcnt = 0;
      end else begin
        m_pcnt = (m_pcnt + 1) % TB_DIV;
        if (m_pcnt == 0) m_mtime = m_mtime + 64'd1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("rvalid", 64'(bus_rvalid), 64'(exp_rvalid));
    check("rdata", 64'(bus_rdata), 64'(exp_rdata));
    check("timer_interrupt", 64'(timer_interrupt), 64'(exp_ti));
    check("software_interrupt", 64'(software_interrupt), 64'(exp_si));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    #1;
    bus_valid = v; bus_we = we; bus_addr = addr; bus_wdata = wd;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic rvalid);
    drive(1'b1, we, addr, wd);
    @(negedge clk);
    rdata = bus_rdata;
    rvalid = bus_rvalid;
    #1;
    bus_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 200));
      1: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      2: return $urandom;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rdat;
    logic        rv;
    logic [31:0] seq_data[5];
    logic        seq_vld[5];
    int          waited;

    idle(4);
    #1 rst_n = 1'b1;

    // Reset values through the bus
    for (int w = 0; w < 8; w++) begin
      access(1'b0, BASE + 32'(w * 4), 32'd0, rdat, rv);
      check("reset_rvalid", 64'(rv), 64'd1);
      if (w == 2 || w == 3) check("reset_mtimecmp", 64'(rdat), 64'hFFFF_FFFF);
      else if (w != 4 && w != 5) check("reset_zero_word", 64'(rdat), 64'd0);
    end
    idle(1000);
    check("ti_idle_1000", 64'(timer_interrupt), 64'd0);

    // Timer compare at 100, then cleared by raising mtimecmp
    access(1'b1, BASE + 32'd20, 32'd0, rdat, rv);
    access(1'b1, BASE + 32'd16, 32'd0, rdat, rv);
    access(1'b1, BASE + 32'd12, 32'd0, rdat, rv);
    access(1'b1, BASE + 32'd8, 32'd100, rdat, rv);
    check("write_rdata_zero", 64'(rdat), 64'd0);
    access(1'b0, BASE + 32'd8, 32'd0, rdat, rv);
    check("mtimecmp_lo_readback", 64'(rdat), 64'd100);
    waited = 0;
    while (!timer_interrupt && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("ti_rise", 64'(timer_interrupt), 64'd1);
    access(1'b1, BASE + 32'd8, 32'hFFFF_FFFF, rdat, rv);
    @(negedge clk);
    check("ti_cleared", 64'(timer_interrupt), 64'd0);

    // Carry from low into high half
    access(1'b1, BASE + 32'd20, 32'd0, rdat, rv);
    access(1'b1, BASE + 32'd16, 32'hFFFF_FFFE, rdat, rv);
    idle(20);
    access(1'b0, BASE + 32'd20, 32'd0, rdat, rv);
    check("mtime_carry_hi", 64'(rdat), 64'd1);

    // Written value is read back unincremented on the very next cycle
    drive(1'b1, 1'b1, BASE + 32'd16, 32'd5);
    drive(1'b1, 1'b0, BASE + 32'd16, 32'd0);
    @(negedge clk);
    check("mtime_lo_write_no_inc", 64'(bus_rdata), 64'd5);
    #1 bus_valid = 1'b0;

    // Software interrupt two cycles after the write
    access(1'b1, BASE, 32'hFFFF_FFFF, rdat, rv);
    @(negedge clk);
    check("si_set", 64'(software_interrupt), 64'd1);
    access(1'b0, BASE, 32'd0, rdat, rv);
    check("msip_readback", 64'(rdat), 64'd1);
    access(1'b1, BASE, 32'd0, rdat, rv);
    @(negedge clk);
    check("si_clear", 64'(software_interrupt), 64'd0);

    // Back-to-back reads of MTIME_LO
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        seq_vld[i-1] = bus_rvalid;
        seq_data[i-1] = bus_rdata;
      end
      #1;
      bus_valid = (i < 4); bus_we = 1'b0; bus_addr = BASE + 32'd16;
    end
    for (int i = 0; i < 4; i++) check("b2b_rvalid", 64'(seq_vld[i]), 64'd1);
    for (int i = 0; i < 3; i++) check("b2b_step_le1", 64'((seq_data[i+1] - seq_data[i]) <= 32'd1), 64'd1);

    // Outside the window
    access(1'b0, BASE + 32'd32, 32'd0, rdat, rv);
    check("out_of_window_rvalid", 64'(rv), 64'd0);
    access(1'b1, BASE - 32'd4, 32'd1, rdat, rv);
    check("below_window_rvalid", 64'(rv), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? BASE + 32'd32 + 32'($urandom_range(0, 31)) : $urandom;
      else a = BASE + 32'($urandom_range(0, 31));
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), a, rand_data());
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    // Asynchronous reset with both interrupts high and a request in flight
    access(1'b1, BASE, 32'd1, rdat, rv);
    access(1'b1, BASE + 32'd12, 32'd0, rdat, rv);
    access(1'b1, BASE + 32'd8, 32'd0, rdat, rv);
    idle(3);
    check("pre_reset_ti", 64'(timer_interrupt), 64'd1);
    check("pre_reset_si", 64'(software_interrupt), 64'd1);
    drive(1'b1, 1'b0, BASE + 32'd16, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rvalid", 64'(bus_rvalid), 64'd0);
    check("async_rst_rdata", 64'(bus_rdata), 64'd0);
    check("async_rst_ti", 64'(timer_interrupt), 64'd0);
    check("async_rst_si", 64'(software_interrupt), 64'd0);
    bus_valid = 1'b0;
    idle(3);
    #1 rst_n = 1'b1;
    access(1'b0, BASE + 32'd12, 32'd0, rdat, rv);
    check("post_reset_mtimecmp_hi", 64'(rdat), 64'hFFFF_FFFF);
    access(1'b0, BASE + 32'd20, 32'd0, rdat, rv);
    check("post_reset_mtime_hi", 64'(rdat), 64'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
